// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate-unit checker: FSM states, gate bit
// positions inside the six-bit gate vectors, and a helper that packs the
// individual gate outputs into that vector layout.
package gate_chk_pkg;

    // Number of two-input gates exercised by the gate unit under check.
    localparam int NUM_GATES = 6;

    // Bit position of each gate inside every six-bit gate vector.
    localparam int AND  = 0;
    localparam int OR   = 1;
    localparam int NAND = 2;
    localparam int NOR  = 3;
    localparam int XOR  = 4;
    localparam int XNOR = 5;

    // Number of distinct {a,b} input combinations tracked for coverage.
    localparam int NUM_COMBOS = 4;

    // Run control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } chkState_t;

    // One bit per gate, indexed by the constants above.
    typedef logic [NUM_GATES-1:0] gateVec_t;

    // Pack six separate gate outputs into the common vector layout.
    function automatic gateVec_t packGates(
        input logic andV,
        input logic orV,
        input logic nandV,
        input logic norV,
        input logic xorV,
        input logic xnorV
    );
        gateVec_t v;
        v       = '0;
        v[AND]  = andV;
        v[OR]   = orV;
        v[NAND] = nandV;
        v[NOR]  = norV;
        v[XOR]  = xorV;
        v[XNOR] = xnorV;
        return v;
    endfunction

endpackage

// File: rtl/gate_ref.sv
// Golden reference for the gate unit: produces the six expected gate
// outputs for a single pair of operands. Purely combinational.
module gate_ref
    import gate_chk_pkg::*;
(
    input  logic     i_a,
    input  logic     i_b,
    output gateVec_t o_expected
);

    // Evaluate every gate from the operands; each bit lands in its named slot.
    always_comb begin
        o_expected       = '0;
        o_expected[AND]  = i_a & i_b;
        o_expected[OR]   = i_a | i_b;
        o_expected[NAND] = ~(i_a & i_b);
        o_expected[NOR]  = ~(i_a | i_b);
        o_expected[XOR]  = i_a ^ i_b;
        o_expected[XNOR] = ~(i_a ^ i_b);
    end

endmodule

// File: rtl/gate_checker.sv
// Run-based checker for a two-input gate unit. A start pulse opens a run of
// VEC_LIMIT valid samples; each sample is compared against the reference
// gates and the results are accumulated into a sticky per-gate error mask,
// a saturating error-sample count and an {a,b} coverage map. The verdict is
// presented once the run completes and held until the next start.
module gate_checker
    import gate_chk_pkg::*;
#(
    parameter int VEC_LIMIT = 16,
    parameter int CNT_W     = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vld,
    input  logic             a,
    input  logic             b,
    input  logic             o_and,
    input  logic             o_or,
    input  logic             o_nand,
    input  logic             o_nor,
    input  logic             o_xor,
    input  logic             o_xnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [5:0]       err_mask,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov
);

    // Sample counter must be able to hold VEC_LIMIT itself once a run ends.
    localparam int                SMP_W    = $clog2(VEC_LIMIT + 1);
    localparam logic [SMP_W-1:0]  LAST_SMP = SMP_W'(VEC_LIMIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [NUM_COMBOS-1:0] COV_FULL = '1;

    chkState_t             r_state;
    chkState_t             w_nextState;
    logic [SMP_W-1:0]      r_smpCnt;
    gateVec_t              r_errMask;
    logic [CNT_W-1:0]      r_errCnt;
    logic [NUM_COMBOS-1:0] r_cov;

    gateVec_t              w_expected;
    gateVec_t              w_observed;
    gateVec_t              w_mismatch;
    logic                  w_accept;
    logic                  w_lastSmp;
    logic                  w_anyErr;
    logic [NUM_COMBOS-1:0] w_covHit;

    gate_ref u_gateRef (
        .i_a        (a),
        .i_b        (b),
        .o_expected (w_expected)
    );

    assign w_observed = packGates(o_and, o_or, o_nand, o_nor, o_xor, o_xnor);
    assign w_mismatch = w_expected ^ w_observed;
    assign w_anyErr   = |w_mismatch;

    // A sample only counts inside a run and never in the cycle a (re)start
    // is being taken, since that cycle is spent clearing the accumulators.
    assign w_accept  = (r_state == ST_CHECK) && vld && !start;
    assign w_lastSmp = w_accept && (r_smpCnt == LAST_SMP);

    // One-hot coverage bit for the operand pair currently presented.
    assign w_covHit = NUM_COMBOS'(1) << {a, b};

    // State register; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: start always (re)enters CHECK, the last sample ends it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (start) begin
                    w_nextState = ST_CHECK;
                end else if (w_lastSmp) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_nextState = ST_CHECK;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Sample counter: cleared by reset or start, advanced per accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_smpCnt <= '0;
        end else if (start) begin
            r_smpCnt <= '0;
        end else if (w_accept) begin
            r_smpCnt <= r_smpCnt + 1'b1;
        end
    end

    // Sticky per-gate mismatch flags, OR-accumulated across the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errMask <= '0;
        end else if (start) begin
            r_errMask <= '0;
        end else if (w_accept) begin
            r_errMask <= r_errMask | w_mismatch;
        end
    end

    // Count samples with any mismatching gate, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errCnt <= '0;
        end else if (start) begin
            r_errCnt <= '0;
        end else if (w_accept && w_anyErr && (r_errCnt != CNT_MAX)) begin
            r_errCnt <= r_errCnt + 1'b1;
        end
    end

    // Record which {a,b} combinations have been seen during the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cov <= '0;
        end else if (start) begin
            r_cov <= '0;
        end else if (w_accept) begin
            r_cov <= r_cov | w_covHit;
        end
    end

    // Status outputs decoded from the current state and accumulated results.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (r_state)
            ST_CHECK: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (r_errCnt == '0) && (r_cov == COV_FULL);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign err_mask = r_errMask;
    assign err_cnt  = r_errCnt;
    assign cov      = r_cov;

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker. Two instances share the operand/sample
// inputs: unit 0 uses the default sizing, unit 1 uses CNT_W=2, VEC_LIMIT=8
// so error-count saturation can be exercised. Stimulus pushes hand-computed
// expected results into a queue; the monitor pops and compares them when a
// unit raises done or when the stimulus asks for a snapshot.
module tb_gate_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0;
    logic       start1;
    logic       vld;
    logic       a;
    logic       b;
    logic       o_and;
    logic       o_or;
    logic       o_nand;
    logic       o_nor;
    logic       o_xor;
    logic       o_xnor;

    logic       busy0;
    logic       done0;
    logic       pass0;
    logic [5:0] errMask0;
    logic [7:0] errCnt0;
    logic [3:0] cov0;

    logic       busy1;
    logic       done1;
    logic       pass1;
    logic [5:0] errMask1;
    logic [1:0] errCnt1;
    logic [3:0] cov1;

    typedef struct {
        bit       isSnap;
        int       unit;
        bit       busy;
        bit       done;
        bit       pass;
        bit [5:0] mask;
        bit [7:0] cnt;
        bit [3:0] cov;
    } exp_t;

    exp_t expQ[$];
    bit   snapReq = 1'b0;
    int   nChecks = 0;
    int   nPass   = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    gate_checker #(.VEC_LIMIT(16), .CNT_W(8)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .vld      (vld),
        .a        (a),
        .b        (b),
        .o_and    (o_and),
        .o_or     (o_or),
        .o_nand   (o_nand),
        .o_nor    (o_nor),
        .o_xor    (o_xor),
        .o_xnor   (o_xnor),
        .busy     (busy0),
        .done     (done0),
        .pass     (pass0),
        .err_mask (errMask0),
        .err_cnt  (errCnt0),
        .cov      (cov0)
    );

    gate_checker #(.VEC_LIMIT(8), .CNT_W(2)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .vld      (vld),
        .a        (a),
        .b        (b),
        .o_and    (o_and),
        .o_or     (o_or),
        .o_nand   (o_nand),
        .o_nor    (o_nor),
        .o_xor    (o_xor),
        .o_xnor   (o_xnor),
        .busy     (busy1),
        .done     (done1),
        .pass     (pass1),
        .err_mask (errMask1),
        .err_cnt  (errCnt1),
        .cov      (cov1)
    );

    // Correct gate truth table, returned as {xnor,xor,nor,nand,or,and}.
    function automatic bit [5:0] goodGates(input bit [1:0] ab);
        case (ab)
            2'b00:   return 6'b101100;
            2'b01:   return 6'b010110;
            2'b10:   return 6'b010110;
            default: return 6'b100011;
        endcase
    endfunction

    // Single comparison: bumps the totals and reports any difference.
    function automatic void cmp(input string name, input int act, input int req);
        nChecks++;
        if (act == req) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Pop the oldest expectation and compare it against the named unit.
    task automatic popCompare(input int unit, input bit isSnap);
        exp_t e;
        int   u;
        if (expQ.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected event: got unit %0d event with empty queue, expected none", unit);
            return;
        end
        e = expQ.pop_front();
        cmp("event kind", int'(isSnap), int'(e.isSnap));
        u = isSnap ? e.unit : unit;
        if (!isSnap) cmp("done unit", unit, e.unit);
        if (u == 0) begin
            cmp("u0 busy", int'(busy0), int'(e.busy));
            cmp("u0 done", int'(done0), int'(e.done));
            cmp("u0 pass", int'(pass0), int'(e.pass));
            cmp("u0 err_mask", int'(errMask0), int'(e.mask));
            cmp("u0 err_cnt", int'(errCnt0), int'(e.cnt));
            cmp("u0 cov", int'(cov0), int'(e.cov));
        end else begin
            cmp("u1 busy", int'(busy1), int'(e.busy));
            cmp("u1 done", int'(done1), int'(e.done));
            cmp("u1 pass", int'(pass1), int'(e.pass));
            cmp("u1 err_mask", int'(errMask1), int'(e.mask));
            cmp("u1 err_cnt", int'(errCnt1), int'(e.cnt));
            cmp("u1 cov", int'(cov1), int'(e.cov));
        end
    endtask

    // Monitor: on each falling edge, a fresh done on either unit or a pending
    // snapshot request consumes the next queued expectation.
    initial begin
        bit prevDone0 = 1'b0;
        bit prevDone1 = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 && !prevDone0) popCompare(0, 1'b0);
            if (done1 && !prevDone1) popCompare(1, 1'b0);
            if (snapReq) popCompare(-1, 1'b1);
            prevDone0 = done0;
            prevDone1 = done1;
        end
    end

    // Present one sample (optionally corrupted by flip) for one clock.
    task automatic applyStimulus(input bit [1:0] ab, input bit [5:0] flip, input bit v);
        {a, b} = ab;
        {o_xnor, o_xor, o_nor, o_nand, o_or, o_and} = goodGates(ab) ^ flip;
        vld = v;
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    // Queue a snapshot expectation and let the monitor sample it once.
    task automatic checkOutput(input int unit, input bit bsy, input bit dn, input bit ps,
                               input bit [5:0] mask, input bit [7:0] cnt, input bit [3:0] cv);
        expQ.push_back('{1'b1, unit, bsy, dn, ps, mask, cnt, cv});
        snapReq = 1'b1;
        @(posedge clk);
        #1;
        snapReq = 1'b0;
    endtask

    // Queue the verdict expected when the unit's run completes.
    task automatic expectDone(input int unit, input bit ps, input bit [5:0] mask,
                              input bit [7:0] cnt, input bit [3:0] cv);
        expQ.push_back('{1'b0, unit, 1'b0, 1'b1, ps, mask, cnt, cv});
    endtask

    // Single-cycle start pulse to the selected unit.
    task automatic pulseStart(input int unit);
        if (unit == 0) start0 = 1'b1;
        else           start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Back-to-back samples numbered first..first+count-1. Operands cycle
    // 00,01,10,11 unless all11 is set. faultIdx selects one corrupted
    // sample, -2 corrupts every sample, -1 none.
    task automatic runSamples(input int first, input int count, input int faultIdx,
                              input bit [5:0] flip, input bit all11);
        for (int i = first; i < first + count; i++) begin
            bit [1:0] ab;
            bit [5:0] f;
            ab = all11 ? 2'b11 : 2'(i % 4);
            f  = ((faultIdx == -2) || (faultIdx == i)) ? flip : 6'b000000;
            applyStimulus(ab, f, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed test sequence.
    initial begin
        int waitCycles;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        vld    = 1'b0;
        {a, b} = 2'b00;
        {o_xnor, o_xor, o_nor, o_nand, o_or, o_and} = 6'b000000;
        idle(3);
        rst_n = 1'b1;

        $display("[TB] reset state and vld ignored in IDLE");
        applyStimulus(2'b10, 6'b111111, 1'b1);
        applyStimulus(2'b01, 6'b000011, 1'b1);
        checkOutput(0, 0, 0, 0, 6'b000000, 8'd0, 4'h0);
        checkOutput(1, 0, 0, 0, 6'b000000, 8'd0, 4'h0);

        $display("[TB] clean run, all combinations");
        pulseStart(0);
        runSamples(0, 15, -1, 6'b0, 1'b0);
        expectDone(0, 1, 6'b000000, 8'd0, 4'hF);
        runSamples(15, 1, -1, 6'b0, 1'b0);
        idle(2);

        $display("[TB] vld ignored in DONE");
        applyStimulus(2'b10, 6'b111111, 1'b1);
        applyStimulus(2'b00, 6'b000001, 1'b1);
        checkOutput(0, 0, 1, 1, 6'b000000, 8'd0, 4'hF);

        $display("[TB] xor fault on a=1 b=0");
        pulseStart(0);
        runSamples(0, 15, 2, 6'b010000, 1'b0);
        expectDone(0, 0, 6'b010000, 8'd1, 4'hF);
        runSamples(15, 1, -1, 6'b0, 1'b0);
        idle(2);

        $display("[TB] incomplete coverage");
        pulseStart(0);
        runSamples(0, 15, -1, 6'b0, 1'b1);
        expectDone(0, 0, 6'b000000, 8'd0, 4'b1000);
        runSamples(15, 1, -1, 6'b0, 1'b1);
        idle(2);

        $display("[TB] reset mid-run");
        pulseStart(0);
        runSamples(0, 5, -1, 6'b0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(2'b01, 6'b000001, 1'b1);
        rst_n = 1'b1;
        checkOutput(0, 0, 0, 0, 6'b000000, 8'd0, 4'h0);
        pulseStart(0);
        runSamples(0, 15, -1, 6'b0, 1'b0);
        expectDone(0, 1, 6'b000000, 8'd0, 4'hF);
        runSamples(15, 1, -1, 6'b0, 1'b0);
        idle(2);

        $display("[TB] restart during CHECK");
        pulseStart(0);
        runSamples(0, 7, 0, 6'b000001, 1'b0);
        checkOutput(0, 1, 0, 0, 6'b000001, 8'd1, 4'hF);
        start0 = 1'b1;
        applyStimulus(2'b11, 6'b111111, 1'b1);
        start0 = 1'b0;
        checkOutput(0, 1, 0, 0, 6'b000000, 8'd0, 4'h0);
        runSamples(0, 15, -1, 6'b0, 1'b0);
        checkOutput(0, 1, 0, 0, 6'b000000, 8'd0, 4'hF);
        expectDone(0, 1, 6'b000000, 8'd0, 4'hF);
        runSamples(15, 1, -1, 6'b0, 1'b0);
        idle(2);

        $display("[TB] error count saturation on small unit");
        pulseStart(1);
        runSamples(0, 5, -2, 6'b000001, 1'b0);
        checkOutput(1, 1, 0, 0, 6'b000001, 8'd3, 4'hF);
        runSamples(5, 2, -2, 6'b000001, 1'b0);
        expectDone(1, 0, 6'b000001, 8'd3, 4'hF);
        runSamples(7, 1, -2, 6'b000001, 1'b0);

        waitCycles = 0;
        while ((expQ.size() != 0) && (waitCycles < 20)) begin
            idle(1);
            waitCycles++;
        end
        while (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            nChecks++;
            $display("[TB] FAIL pending expectation: got no event from unit %0d, expected done=%0d", e.unit, e.done);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
